// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC router definitions: port indices, flit geometry
//                and the output-register state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

   // Router port indices
   localparam int PORT_N    = 0;
   localparam int PORT_E    = 1;
   localparam int PORT_S    = 2;
   localparam int PORT_W    = 3;
   localparam int PORT_L    = 4;
   localparam int NUM_PORTS = 5;

   // Flit geometry: destination X/Y live in the flit MSBs
   localparam int FLIT_WIDTH = 288;
   localparam int POS_WIDTH  = 4;

   // One-flit output register occupancy
   typedef enum logic [0:0] {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_outport_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_outport_arbiter_if
//  Description : Holding-register request side and valid/ready output link of
//                one router output direction.
//                master : the arbiter (drives clear and the link)
//                slave  : the surrounding router / link sink
//  Revision    : 1.0 - initial release
// ============================================================================
interface noc_outport_arbiter_if #(
   parameter int DATA_WIDTH = 288,
   parameter int NUM_IN     = 5
);

   logic [NUM_IN-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_IN-1:0]                 req_valid;
   logic [NUM_IN-1:0]                 clear;
   logic [DATA_WIDTH-1:0]             link_data;
   logic                              link_valid;
   logic                              link_ready;

   modport master (
      input  req_data,
      input  req_valid,
      output clear,
      output link_data,
      output link_valid,
      input  link_ready
   );

   modport slave (
      output req_data,
      output req_valid,
      input  clear,
      input  link_data,
      input  link_valid,
      output link_ready
   );

endinterface : noc_outport_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational circular priority encoder. Scans the request
//                vector starting at ptr and wrapping modulo N (N need not be
//                a power of two); returns a one-hot grant and its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   // First set request at or after ptr, circularly
   always_comb begin
      logic [IDX_W-1:0] w_sel;
      logic             w_found;
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < N; k++) begin
         w_sel = IDX_W'((int'(ptr) + k) % N);
         if (!w_found && req[w_sel]) begin
            w_found      = 1'b1;
            gnt[w_sel]   = 1'b1;
            gnt_idx      = w_sel;
         end
      end
      gnt_any = w_found;
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/noc_outport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : noc_outport_arbiter
//  Description : Output side of one router direction. Round-robin selects one
//                of the input-switch holding registers per cycle, pulses
//                clear back to the winner and loads a one-flit output
//                register that drives a valid/ready link. Provides grant
//                enable, idle status, flit/stall counters and a sticky
//                U-turn error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_outport_arbiter
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = FLIT_WIDTH,
   parameter int NUM_IN     = NUM_PORTS,
   parameter int DIR        = PORT_N,
   parameter int NO_UTURN   = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   noc_outport_arbiter_if.master bus,
   input  logic                  en,
   output logic                  idle,
   output logic [CNT_WIDTH-1:0]  stat_flits,
   output logic [CNT_WIDTH-1:0]  stat_stall,
   output logic                  err_uturn
);

   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   out_state_e              r_state;
   out_state_e              w_state_nxt;
   logic [NUM_IN-1:0]       w_elig;
   logic [NUM_IN-1:0]       w_gnt;
   logic [IDX_W-1:0]        w_gnt_idx;
   logic                    w_gnt_any;
   logic                    w_slot_free;
   logic                    w_grant;
   logic                    w_link_valid;
   logic [IDX_W-1:0]        w_ptr_nxt;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [NUM_IN-1:0]       r_clear;
   logic [DATA_WIDTH-1:0]   r_link_data;
   logic [CNT_WIDTH-1:0]    r_stat_flits;
   logic [CNT_WIDTH-1:0]    r_stat_stall;
   logic                    r_err_uturn;

   // A holder being cleared this cycle still shows valid, so it is masked
   // to avoid granting the same flit twice; the U-turn input is never eligible.
   for (genvar i = 0; i < NUM_IN; i++) begin : g_elig
      localparam bit BLOCKED = (NO_UTURN != 0) && (i == DIR);
      assign w_elig[i] = bus.req_valid[i] & ~r_clear[i] & ~BLOCKED;
   end

   rr_arbiter #(
      .N     (NUM_IN),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req     (w_elig),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .gnt_any (w_gnt_any)
   );

   assign w_link_valid = (r_state == OUT_FULL);
   assign w_slot_free  = ~w_link_valid | bus.link_ready;
   assign w_grant      = en & w_slot_free & w_gnt_any;
   assign w_ptr_nxt    = (w_gnt_idx == IDX_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

   // Output register occupancy state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= OUT_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Next occupancy: a grant refills (even while draining), a drain alone empties
   always_comb begin
      w_state_nxt = r_state;
      if (w_grant)
         w_state_nxt = OUT_FULL;
      else if (w_link_valid && bus.link_ready)
         w_state_nxt = OUT_EMPTY;
   end

   // Flit capture, release pulse and round-robin pointer update on grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_link_data <= '0;
         r_clear     <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_clear <= w_grant ? w_gnt : '0;
         if (w_grant) begin
            r_link_data <= bus.req_data[w_gnt_idx];
            r_rr_ptr    <= w_ptr_nxt;
         end
      end
   end

   // Link statistics and sticky U-turn error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_flits <= '0;
         r_stat_stall <= '0;
         r_err_uturn  <= 1'b0;
      end else begin
         if (w_link_valid && bus.link_ready)
            r_stat_flits <= r_stat_flits + CNT_WIDTH'(1);
         if (w_link_valid && !bus.link_ready)
            r_stat_stall <= r_stat_stall + CNT_WIDTH'(1);
         if ((NO_UTURN != 0) && bus.req_valid[DIR])
            r_err_uturn <= 1'b1;
      end
   end

   assign bus.clear      = r_clear;
   assign bus.link_data  = r_link_data;
   assign bus.link_valid = w_link_valid;
   assign idle           = ~w_link_valid & ~(|w_elig);
   assign stat_flits     = r_stat_flits;
   assign stat_stall     = r_stat_stall;
   assign err_uturn      = r_err_uturn;

endmodule : noc_outport_arbiter
`default_nettype wire
